// File: rtl/ab_and_checker_if.sv
// Port bundle for ab_and_checker: run control, the two checked signals,
// and the result outputs.
interface ab_and_checker_if #(
    parameter int CNT_W = 8
);
    // start is a level request: it is taken on any posedge in IDLE and ignored
    // elsewhere; done is a one-cycle pulse, with results held until the next accepted start.
    logic             start;
    logic [CNT_W-1:0] num_samples;
    logic             a;
    logic             b;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] pass_cnt;
    logic [CNT_W-1:0] fail_cnt;
    logic [CNT_W-1:0] first_fail_idx;
    logic             fail_seen;
    logic             streak_err;

    modport master (
        output start, num_samples, a, b,
        input  busy, done, pass_cnt, fail_cnt, first_fail_idx, fail_seen, streak_err
    );

    modport slave (
        input  start, num_samples, a, b,
        output busy, done, pass_cnt, fail_cnt, first_fail_idx, fail_seen, streak_err
    );
endinterface

// File: rtl/ab_and_checker.sv
// Checks a&b over num_samples consecutive cycles, counting passes and failures,
// and flagging the first failure and any run of FAIL_LIMIT consecutive failures.
module ab_and_checker #(
    parameter int CNT_W      = 8,
    parameter int FAIL_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    ab_and_checker_if.slave   bus,
    output logic [1:0]        dbg_state
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CHECK = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(FAIL_LIMIT);

    logic [1:0]       state;
    logic [CNT_W-1:0] num_q;
    logic [CNT_W-1:0] idx;
    logic [CNT_W-1:0] streak;
    logic [CNT_W-1:0] pass_q;
    logic [CNT_W-1:0] fail_q;
    logic [CNT_W-1:0] ffi_q;
    logic             fseen_q;
    logic             serr_q;
    logic             sample_ok;
    logic [CNT_W-1:0] streak_inc;

    assign sample_ok  = bus.a & bus.b;
    // Saturate at LIMIT so a long failure run can never wrap the streak count.
    assign streak_inc = (streak == LIMIT) ? streak : streak + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            num_q   <= '0;
            idx     <= '0;
            streak  <= '0;
            pass_q  <= '0;
            fail_q  <= '0;
            ffi_q   <= '0;
            fseen_q <= 1'b0;
            serr_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        num_q   <= bus.num_samples;
                        idx     <= '0;
                        streak  <= '0;
                        pass_q  <= '0;
                        fail_q  <= '0;
                        ffi_q   <= '0;
                        fseen_q <= 1'b0;
                        serr_q  <= 1'b0;
                        state   <= (bus.num_samples == '0) ? DONE : CHECK;
                    end
                end
                CHECK: begin
                    if (sample_ok) begin
                        pass_q <= pass_q + 1'b1;
                        streak <= '0;
                    end else begin
                        fail_q <= fail_q + 1'b1;
                        streak <= streak_inc;
                        if (streak_inc == LIMIT) serr_q <= 1'b1;
                        if (!fseen_q) begin
                            ffi_q   <= idx;
                            fseen_q <= 1'b1;
                        end
                    end
                    idx <= idx + 1'b1;
                    if (idx == num_q - 1'b1) state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy           = (state == CHECK);
    assign bus.done           = (state == DONE);
    assign bus.pass_cnt       = pass_q;
    assign bus.fail_cnt       = fail_q;
    assign bus.first_fail_idx = ffi_q;
    assign bus.fail_seen      = fseen_q;
    assign bus.streak_err     = serr_q;
    assign dbg_state          = state;
endmodule
